uart_rx_frame_ctrl: RTL and testbench

Frame controller for the UART receiver. It detects the start bit and generates the per-bit edge counter plus the sampling enable that drive the majority-vote data sampler. It consumes that sampler's sampled_bit to check the start bit, deserialize 8 data bits LSB-first, check optional parity and check the stop bit. A validated byte is presented on P_DATA with a one-cycle data_valid pulse.

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_frame_ctrl_edge_bit_counter.sv | 56 +++++
 rtl/uart_rx_frame_ctrl.sv | 141 ++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver frame path.
// Holds the frame FSM state encoding, the data width and the legal oversampling ratios.
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned PRESCALE_W = 6;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_edge_bit_counter.sv
// Oversample edge counter and bit counter for the UART receiver.
// edge_count wraps at prescale-1 and advances bit_count; bit_end_o flags that cycle.
module edge_bit_counter #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  bit_clr_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_count_o,
  output logic [BIT_CNT_W-1:0]  bit_count_o,
  output logic                  bit_end_o
);

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic                  wrap;

  assign wrap      = (edge_q == (prescale_i - PRESCALE_W'(1)));
  assign bit_end_o = en_i && wrap;

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr_i) begin
      edge_d = '0;
    end else if (en_i) begin
      if (wrap) begin
        edge_d = '0;
        bit_d  = bit_q + BIT_CNT_W'(1);
      end else begin
        edge_d = edge_q + PRESCALE_W'(1);
      end
    end
    if (bit_clr_i) begin
      bit_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_count_o = edge_q;
  assign bit_count_o  = bit_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receiver frame controller: start detection, bit timing, deserialization,
// parity/stop checking and delivery of validated bytes on P_DATA with data_valid.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = uart_rx_pkg::DATA_WIDTH,
  parameter int unsigned PRESCALE_W = uart_rx_pkg::PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic                  dat_samp_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  import uart_rx_pkg::*;

  // Start bit is bit 0, data bits are 1..DATA_WIDTH, then parity/stop.
  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 4);

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;
  logic                  data_valid_q, data_valid_d;

  logic                  cnt_en;
  logic                  start_det;
  logic                  bit_end;
  logic [BIT_CNT_W-1:0]  bit_count;

  assign start_det = (state_q == IDLE) && !RX_IN;
  // Gated with rstn so the sampler enable also drops while reset is held.
  assign cnt_en    = rstn && ((state_q != IDLE) || !RX_IN);

  edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_edge_bit_counter (
    .clk          (clk),
    .rstn         (rstn),
    .en_i         (cnt_en),
    .clr_i        ((state_q == IDLE) && RX_IN),
    .bit_clr_i    (state_q == IDLE),
    .prescale_i   (prescale),
    .edge_count_o (edge_count),
    .bit_count_o  (bit_count),
    .bit_end_o    (bit_end)
  );

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    parity_error_d = parity_error_q;
    stop_error_d   = stop_error_q;
    data_valid_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_det) begin
          state_d        = START;
          parity_error_d = 1'b0;
          stop_error_d   = 1'b0;
          par_en_d       = PAR_EN;
          par_typ_d      = PAR_TYP;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = sampled_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_count == BIT_CNT_W'(DATA_WIDTH)) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          parity_error_d = (sampled_bit != ((^shift_q) ^ par_typ_q));
          state_d        = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          stop_error_d = ~sampled_bit;
          if (sampled_bit && !(par_en_q && parity_error_q)) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      p_data_q       <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      data_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
      data_valid_q   <= data_valid_d;
    end
  end

  assign dat_samp_en  = cnt_en;
  assign P_DATA       = p_data_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: frames are built bit-by-bit from a byte,
// expected deliveries (data + arrival cycle) are queued and checked by a monitor.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       noise = 1'b0;
  logic       sampled_bit;
  logic [5:0] edge_count;
  logic       dat_samp_en;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_pdata = 8'h00;

  uart_rx_frame_ctrl #(
    .DATA_WIDTH (8),
    .PRESCALE_W (6)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .RX_IN        (RX_IN),
    .prescale     (prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .sampled_bit  (sampled_bit),
    .edge_count   (edge_count),
    .dat_samp_en  (dat_samp_en),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sampler stand-in: the true line value only on the bit-end cycle, noise elsewhere.
  assign sampled_bit = (edge_count == prescale - 6'd1) ? RX_IN : noise;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      noise = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn && data_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 expected=0 P_DATA=%0h (cycle %0d)", P_DATA, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("P_DATA", int'(P_DATA), int'(e.data));
        chk("valid_cycle", cyc, e.cyc);
        chk("flags_at_valid", int'({parity_error, stop_error}), 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] data, input int ps, input logic pe,
                            input logic typ, input logic flip, input logic stopb);
    logic bits[$];
    int   nbits;
    int   d;
    logic perr;
    logic serr;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pe) bits.push_back((^data) ^ typ ^ flip);
    bits.push_back(stopb);
    nbits = bits.size();
    perr = pe && flip;
    serr = !stopb;
    d = cyc;
    if (!perr && !serr) begin
      sb.push_back('{data: data, cyc: d + ps * nbits});
      model_pdata = data;
    end
    prescale = 6'(ps);
    PAR_EN = pe;
    PAR_TYP = typ;
    for (int b = 0; b < nbits; b++) begin
      RX_IN = bits[b];
      for (int k = 0; k < ps; k++) begin
        @(posedge clk);
        #1;
        if (b == 0 && k == 0) begin
          chk("edge_after_detect", int'(edge_count), 1);
          chk("flags_cleared", int'({parity_error, stop_error}), 0);
          // Frame configuration must already be latched.
          PAR_EN = 1'($urandom_range(0, 1));
          PAR_TYP = 1'($urandom_range(0, 1));
        end
      end
    end
    chk("parity_error_end", int'(parity_error), int'(perr));
    chk("stop_error_end", int'(stop_error), int'(serr));
    chk("P_DATA_end", int'(P_DATA), int'(model_pdata));
    chk("edge_end", int'(edge_count), 0);
    RX_IN = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    tick(3);
    chk("rst_edge_count", int'(edge_count), 0);
    chk("rst_outputs", int'({dat_samp_en, data_valid, parity_error, stop_error}), 0);
    chk("rst_P_DATA", int'(P_DATA), 0);
    rstn = 1'b1;
    idle(3);
    chk("idle_edge_count", int'(edge_count), 0);
    chk("idle_samp_en", int'(dat_samp_en), 0);

    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    send_frame(8'h3C ^ 8'h00, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(2);
    send_frame(8'hC3, 16, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Start-bit glitch: low for two cycles only.
    prescale = 6'd8;
    RX_IN = 1'b0;
    #1;
    chk("detect_samp_en", int'(dat_samp_en), 1);
    tick(1);
    chk("glitch_edge1", int'(edge_count), 1);
    tick(1);
    RX_IN = 1'b1;
    tick(5);
    chk("glitch_edge7", int'(edge_count), 7);
    tick(1);
    chk("glitch_edge_idle", int'(edge_count), 0);
    chk("glitch_samp_en", int'(dat_samp_en), 0);
    chk("glitch_flags", int'({parity_error, stop_error}), 0);
    chk("glitch_P_DATA", int'(P_DATA), int'(model_pdata));
    idle(3);
    chk("glitch_stays_idle", int'(edge_count), 0);

    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    send_frame(8'h12, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hEF, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset in the middle of the second data bit.
    prescale = 6'd16;
    RX_IN = 1'b0;
    tick(16);
    RX_IN = 1'b0;
    tick(16);
    RX_IN = 1'b1;
    tick(5);
    #2;
    RX_IN = 1'b0;
    rstn = 1'b0;
    #1;
    model_pdata = 8'h00;
    chk("midrst_edge_count", int'(edge_count), 0);
    chk("midrst_outputs", int'({dat_samp_en, data_valid, parity_error, stop_error}), 0);
    chk("midrst_P_DATA", int'(P_DATA), 0);
    tick(3);
    RX_IN = 1'b1;
    rstn = 1'b1;
    idle(3);
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    for (int n = 0; n < 20; n++) begin
      int         sel;
      int         ps;
      logic [7:0] data;
      sel = $urandom_range(0, 2);
      ps = (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
      data = 8'($urandom);
      send_frame(data, ps, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
